instr_decode_stage: RTL

//  Registered decode stage between fetch and register-file read. Splits each instruction into its fields
//  and generates the sign-extended immediate for R/I/S/B/U/J formats. Flags illegal encodings.

---
 rtl/rv_decode_pkg.sv | 43 ++++
 rtl/rv_imm_gen.sv | 71 +++++++
 rtl/instr_decode_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// Shared definitions for the RV32 decode stage.
//   - Opcode constants for every supported major opcode
//   - Instruction format encodings reported on the fmt output
//   - Skid-buffer occupancy states
//   - Packed record of the sliced instruction fields held per buffer entry
package rv_decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [6:0] func7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] func3;
        logic [4:0] rd;
        logic [6:0] opcode;
        logic [2:0] fmt;
        logic       illegal;
    } dec_fields_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational format classifier and immediate generator.
//   instr   in   32    raw RV32 instruction word
//   imm     out  XLEN  sign-extended immediate (0 for R-type and illegal)
//   fmt     out  3     format code R/I/S/B/U/J/ILL
//   illegal out  1     unsupported opcode or non-32-bit encoding
module rv_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
    import rv_decode_pkg::*;

    // Every immediate is first assembled as a signed 32-bit value, then widened.
    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic signed [31:0] imm_i_p0;
    logic signed [31:0] imm_s_p0;
    logic signed [31:0] imm_b_p0;
    logic signed [31:0] imm_u_p0;
    logic signed [31:0] imm_j_p0;

    always_comb begin
        imm_i_p0 = {{20{instr[31]}}, instr[31:20]};
        imm_s_p0 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b_p0 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u_p0 = {instr[31:12], 12'b0};
        imm_j_p0 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    always_comb begin
        imm     = '0;
        fmt     = FMT_ILL;
        illegal = 1'b1;
        if (instr[1:0] == 2'b11) begin
            illegal = 1'b0;
            case (instr[6:0])
                OP_R:                       fmt = FMT_R;
                OP_IMM, OP_LOAD, OP_JALR: begin
                    fmt = FMT_I;
                    imm = sext32(imm_i_p0);
                end
                OP_STORE: begin
                    fmt = FMT_S;
                    imm = sext32(imm_s_p0);
                end
                OP_BRANCH: begin
                    fmt = FMT_B;
                    imm = sext32(imm_b_p0);
                end
                OP_LUI, OP_AUIPC: begin
                    fmt = FMT_U;
                    imm = sext32(imm_u_p0);
                end
                OP_JAL: begin
                    fmt = FMT_J;
                    imm = sext32(imm_j_p0);
                end
                default: begin
                    fmt     = FMT_ILL;
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage between fetch and register-file read.
// Decodes the incoming word combinationally and stores the result in a
// 2-entry (head + skid) buffer with valid/ready handshakes on both sides.
//   clk, reset           clock, synchronous active-high reset
//   flush                drop every buffered and same-cycle incoming entry
//   in_valid/in_ready    fetch handshake; in_instr, in_pc payload
//   out_valid/out_ready  downstream handshake
//   out_pc, opcode, rd, func3, rs1, rs2, func7, imm, fmt, illegal
//                        decoded head entry (all zero while out_valid=0)
module instr_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
    import rv_decode_pkg::*;

    logic [XLEN-1:0] dec_imm_p0;
    logic [2:0]      dec_fmt_p0;
    logic            dec_ill_p0;
    dec_fields_t     dec_p0;

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr   (in_instr),
        .imm     (dec_imm_p0),
        .fmt     (dec_fmt_p0),
        .illegal (dec_ill_p0)
    );

    always_comb begin
        dec_p0.func7   = in_instr[31:25];
        dec_p0.rs2     = in_instr[24:20];
        dec_p0.rs1     = in_instr[19:15];
        dec_p0.func3   = in_instr[14:12];
        dec_p0.rd      = in_instr[11:7];
        dec_p0.opcode  = in_instr[6:0];
        dec_p0.fmt     = dec_fmt_p0;
        dec_p0.illegal = dec_ill_p0;
    end

    // ---- p0 -> p1: head / skid entry registers ----
    dec_fields_t     head_f_p1,   skid_f_p1;
    logic [XLEN-1:0] head_imm_p1, skid_imm_p1;
    logic [PC_W-1:0] head_pc_p1,  skid_pc_p1;

    state_t st_q, st_d;
    logic   rdy_en_q;   // holds in_ready low through reset and its release edge
    logic   accept, pop;
    logic   ld_head, ld_skid, promote;

    assign out_valid = (st_q != ST_EMPTY);
    assign in_ready  = rdy_en_q & (st_q != ST_FULL);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        st_d    = st_q;
        ld_head = 1'b0;
        ld_skid = 1'b0;
        promote = 1'b0;
        if (flush) begin
            st_d = ST_EMPTY;
        end else begin
            case (st_q)
                ST_EMPTY: begin
                    if (accept) begin
                        ld_head = 1'b1;
                        st_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        ld_head = 1'b1;
                    end else if (accept) begin
                        ld_skid = 1'b1;
                        st_d    = ST_FULL;
                    end else if (pop) begin
                        st_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        promote = 1'b1;
                        st_d    = ST_ONE;
                    end
                end
                default: st_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q     <= ST_EMPTY;
            rdy_en_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_head) begin
            head_f_p1   <= dec_p0;
            head_imm_p1 <= dec_imm_p0;
            head_pc_p1  <= in_pc;
        end else if (promote) begin
            head_f_p1   <= skid_f_p1;
            head_imm_p1 <= skid_imm_p1;
            head_pc_p1  <= skid_pc_p1;
        end
        if (ld_skid) begin
            skid_f_p1   <= dec_p0;
            skid_imm_p1 <= dec_imm_p0;
            skid_pc_p1  <= in_pc;
        end
    end

    // ---- p1 -> outputs: payload forced to zero whenever nothing is valid ----
    always_comb begin
        out_pc  = out_valid ? head_pc_p1         : '0;
        opcode  = out_valid ? head_f_p1.opcode   : '0;
        rd      = out_valid ? head_f_p1.rd       : '0;
        func3   = out_valid ? head_f_p1.func3    : '0;
        rs1     = out_valid ? head_f_p1.rs1      : '0;
        rs2     = out_valid ? head_f_p1.rs2      : '0;
        func7   = out_valid ? head_f_p1.func7    : '0;
        imm     = out_valid ? head_imm_p1        : '0;
        fmt     = out_valid ? head_f_p1.fmt      : '0;
        illegal = out_valid ? head_f_p1.illegal  : 1'b0;
    end

endmodule
